// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, oversampling ratio, default frame shape
// and the parity helper. The receiver uses the same state encoding.
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;
  localparam int MAX_DBIT        = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uartState_e;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic calcParity(input logic [MAX_DBIT-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Request/status bundle between the TX fifo read side and the UART transmitter.
interface uart_transmitter_if
  import uart_pkg::*;
#(
  parameter int DBIT = DEFAULT_DBIT
);

  logic            tx_start;
  logic [DBIT-1:0] tx_dataIn;
  logic            tx_busy;
  logic            tx_doneTick;

  modport master (
    output tx_start,
    output tx_dataIn,
    input  tx_busy,
    input  tx_doneTick
  );

  modport slave (
    input  tx_start,
    input  tx_dataIn,
    output tx_busy,
    output tx_doneTick
  );

endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period,
// all timed by the shared 16x oversampling tick from baud_gen.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DBIT       = DEFAULT_DBIT,
  parameter int SB_TICK    = DEFAULT_SB_TICK,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_tick,
  uart_transmitter_if.slave txIf,
  output logic              tx
);

  localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

  uartState_e      stateReg, stateNext;
  logic [S_W-1:0]  sReg, sNext;
  logic [N_W-1:0]  nReg, nNext;
  logic [DBIT-1:0] shiftReg, shiftNext;
  logic            parReg, parNext;
  logic            txReg, txNext;
  logic            doneTick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
      sReg     <= '0;
      nReg     <= '0;
      shiftReg <= '0;
      parReg   <= 1'b0;
      txReg    <= 1'b1;
    end else begin
      stateReg <= stateNext;
      sReg     <= sNext;
      nReg     <= nNext;
      shiftReg <= shiftNext;
      parReg   <= parNext;
      txReg    <= txNext;
    end
  end

  // Acceptance happens on any clk in IDLE; every later step waits for s_tick.
  always_comb begin
    stateNext = stateReg;
    sNext     = sReg;
    nNext     = nReg;
    shiftNext = shiftReg;
    parNext   = parReg;
    doneTick  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (txIf.tx_start) begin
          shiftNext = txIf.tx_dataIn;
          parNext   = calcParity(MAX_DBIT'(txIf.tx_dataIn), PARITY_ODD);
          sNext     = '0;
          stateNext = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (sReg == S_BIT_LAST) begin
            sNext     = '0;
            nNext     = '0;
            stateNext = DATA;
          end else begin
            sNext = sReg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (sReg == S_BIT_LAST) begin
            sNext     = '0;
            shiftNext = shiftReg >> 1;
            if (nReg == N_LAST) begin
              stateNext = PARITY_EN ? PARITY : STOP;
            end else begin
              nNext = nReg + 1'b1;
            end
          end else begin
            sNext = sReg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (sReg == S_BIT_LAST) begin
            sNext     = '0;
            stateNext = STOP;
          end else begin
            sNext = sReg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (sReg == S_STOP_LAST) begin
            sNext     = '0;
            doneTick  = 1'b1;
            stateNext = IDLE;
          end else begin
            sNext = sReg + 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // The line level is decoded from the upcoming state so tx stays a clean flop output.
  always_comb begin
    txNext = 1'b1;
    case (stateNext)
      IDLE:    txNext = 1'b1;
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
      PARITY:  txNext = parNext;
      STOP:    txNext = 1'b1;
      default: txNext = 1'b1;
    endcase
  end

  assign tx               = txReg;
  assign txIf.tx_busy     = (stateReg != IDLE);
  assign txIf.tx_doneTick = doneTick;

  // The fifo read side relies on these: it pops on tx_doneTick and re-requests once idle.
  assert property (@(posedge clk) disable iff (!reset_n) txIf.tx_doneTick |=> !txIf.tx_busy);
  assert property (@(posedge clk) disable iff (!reset_n) !txIf.tx_busy |-> txReg);

endmodule
